// File: rtl/usb_byte_fifo_if.sv
// Byte stream handshake: data qualified by valid, accepted when ready is high.
interface usb_byte_fifo_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  // Producer side of the stream.
  modport master (output data, output valid, input ready);
  // Consumer side of the stream.
  modport slave (input data, input valid, output ready);
endinterface

// File: rtl/usb_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with fill level, almost-full
// and sticky overflow flags. The head byte is kept in a register so that the
// read-side data is a clean flop output and holds while the FIFO is empty.
module usb_byte_fifo #(
  parameter  int DEPTH       = 16,
  parameter  int AFULL_LEVEL = 12,
  localparam int AW          = $clog2(DEPTH),
  localparam int LW          = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  usb_byte_fifo_if.slave    s_bus,
  usb_byte_fifo_if.master   m_bus,
  output logic [LW-1:0]     level_o,
  output logic              almost_full_o,
  output logic              overflow_o
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
  logic [LW-1:0] level, level_n;
  logic [7:0]    head, head_n;
  logic          ovf;
  logic          full, empty, push, pop;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // Write side never looks at the read side, so no ready-to-ready path.
  assign s_bus.ready = !full && !rst_i && !flush_i;
  assign m_bus.valid = !empty;
  assign m_bus.data  = head;

  assign push = s_bus.valid && s_bus.ready;
  assign pop  = m_bus.valid && m_bus.ready && !rst_i && !flush_i;

  assign level_o       = level;
  assign almost_full_o = (level >= LW'(AFULL_LEVEL));
  assign overflow_o    = ovf;

  // Next read pointer, level and head byte after this edge.
  always_comb begin
    rd_ptr_n = pop ? rd_ptr + AW'(1) : rd_ptr;
    level_n  = level;
    case ({push, pop})
      2'b10:   level_n = level + LW'(1);
      2'b01:   level_n = level - LW'(1);
      default: level_n = level;
    endcase
    // The new head is the incoming byte only when it lands exactly in the slot
    // the read pointer will point at (FIFO empty, or one entry being popped).
    head_n = head;
    if (level_n != '0) begin
      if (push && (wr_ptr == rd_ptr_n)) head_n = s_bus.data;
      else                              head_n = mem[rd_ptr_n];
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= s_bus.data;
  end

  // Pointers, level, head register and sticky overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      head   <= 8'h00;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      level <= level_n;
      head  <= head_n;
      if (s_bus.valid && full) ovf <= 1'b1;
    end
  end

endmodule
